clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
Measures an incoming slow, asynchronous clock against the board clock CCLK. It reports the half-period of that clock in CCLK cycles and the equivalent divider scale value. This is the receive-side counterpart to the team's clock divider, used to confirm that divided or external clocks run at the intended rate. It raises a timeout when the clock stalls and a lock flag when the measurements are stable.

Parameters:
WIDTH, 32, width of the cycle counter and of all measurement outputs.
TIMEOUT_CYCLES, 100000000, number of CCLK cycles without an edge before timeout is declared.
TOL, 1, maximum absolute difference between consecutive measurements that still counts as stable.

Ports:
CCLK  input  1  system clock; all logic is on its rising edge.
RST  input  1  asynchronous, active-high reset.
enable  input  1  measurement enable; low forces IDLE.
clk_in  input  1  asynchronous clock under measurement.
half_period  output  WIDTH  CCLK cycles between the last two detected clk_in edges.
scale_est  output  WIDTH  half_period - 1, saturating at 0; this is the divider scale value that would produce the measured clock.
valid  output  1  one-cycle pulse when half_period and scale_est update.
locked  output  1  high while consecutive measurements agree within TOL.
timeout  output  1  high while clk_in is stalled.

Behaviour:
- Clock and reset: one clock, CCLK. RST is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, counter 0, synchroniser flops 0.
- Input synchronisation:
  - clk_in passes through a 2-flop synchroniser, then a history flop.
  - An edge is detected when the synchronised value differs from the history value. Both rising and falling edges count, so the block measures half-periods.
- Edge latency: an edge is detected 3 CCLK cycles after the clk_in transition. valid asserts on the cycle after detection.
- Counter:
  - Loads 1 on the cycle after each detected edge and increments every cycle thereafter.
  - Saturates at TIMEOUT_CYCLES and never wraps.
  - Edges N cycles apart capture half_period = N.
- States:
  - IDLE: counter held at 0, locked = 0, timeout = 0. Leave to ARM when enable = 1.
  - ARM: waits for the first edge, with no output update. On edge go to MEASURE and start the counter. If the counter reaches TIMEOUT_CYCLES go to STALL.
  - MEASURE: on each edge, capture the counter into half_period, update scale_est, pulse valid, and restart the counter. If the counter reaches TIMEOUT_CYCLES with no edge, go to STALL.
  - STALL: timeout = 1, locked = 0, valid is never pulsed. An edge clears timeout and goes to MEASURE, treated as a first edge with no capture.
- Enable low in any state forces IDLE on the next cycle:
  - half_period and scale_est hold their last values.
  - locked and timeout clear.
- Lock rule:
  - On each capture, compare the new value with the previous capture. If |new - prev| <= TOL, set locked; otherwise clear it.
  - The first capture after ARM or STALL never sets locked.
- Simultaneous events:
  - An edge on the same cycle the counter reaches TIMEOUT_CYCLES is treated as an edge: capture, no timeout.
  - enable falling on an edge cycle: IDLE wins, no capture.
- RST mid-measurement aborts immediately. All state returns to reset values, including half_period.
- Arithmetic is unsigned WIDTH bits. The difference for TOL uses the larger value minus the smaller.

Test Plan:
- Reset, then enable = 1 with clk_in toggling every 5 CCLK cycles -> first valid carries half_period = 5 and scale_est = 4, locked = 0. The second valid has locked = 1, and valid pulses every 5 cycles after that.
- clk_in toggling every CCLK cycle -> half_period = 1, scale_est = 0, and locked asserts by the second capture.
- TIMEOUT_CYCLES = 64 with clk_in held after lock -> timeout = 1 and locked = 0 exactly 64 cycles after the last edge counter load. The next edge clears timeout with no valid; the following edge gives valid.
- Period changes from 5 to 9 cycles while locked (TOL = 1) -> the first capture of 9 clears locked, and the next capture of 9 sets it again.
- Jitter: alternating spacings of 6 and 7 cycles with TOL = 1 -> locked stays 1. Alternating 6 and 8 -> locked stays 0.
- Assert RST or deassert enable mid-count, and hit the edge/timeout coincidence -> RST gives all outputs 0 asynchronously. enable = 0 holds half_period and clears locked. An edge on the exact timeout cycle captures TIMEOUT_CYCLES with timeout staying 0.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures half-periods of an asynchronous clock in CCLK cycles.
// Reports divider scale estimate, lock on stable readings and stall timeout.
module clk_period_meter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int TOL            = 1
) (
    input  logic             CCLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             clk_in,
    output logic [WIDTH-1:0] half_period,
    output logic [WIDTH-1:0] scale_est,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] TMAX = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] TOLV = WIDTH'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        STALL
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             sync1;
    logic             sync2;
    logic             hist;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] diff;
    logic             lock_q;
    logic             have_prev;
    logic             edge_det;
    logic             at_max;
    logic             capture;

    assign edge_det = sync2 ^ hist;
    assign at_max   = (cnt == TMAX);
    assign capture  = (state == MEASURE) && enable && edge_det;
    assign diff     = (cnt >= half_period) ? (cnt - half_period)
                                           : (half_period - cnt);

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= clk_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = ARM;
                ARM, MEASURE: begin
                    if (edge_det) begin
                        state_nx = MEASURE;
                    end else if (at_max) begin
                        state_nx = STALL;
                    end
                end
                STALL: begin
                    if (edge_det) begin
                        state_nx = MEASURE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Edge wins over saturation: the counter reloads even when already at max.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (!enable || state == IDLE) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= WIDTH'(1);
        end else if (!at_max) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            half_period <= '0;
            scale_est   <= '0;
            valid       <= 1'b0;
            lock_q      <= 1'b0;
            have_prev   <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                half_period <= cnt;
                scale_est   <= (cnt == '0) ? '0 : (cnt - WIDTH'(1));
                lock_q      <= have_prev && (diff <= TOLV);
                have_prev   <= 1'b1;
            end else if (state != MEASURE || !enable) begin
                lock_q    <= 1'b0;
                have_prev <= 1'b0;
            end
        end
    end

    always_comb begin
        timeout = (state == STALL);
        locked  = lock_q && (state == MEASURE);
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized and directed checks of clk_period_meter
// against a spacing-based reference model.
module tb_clk_period_meter;

    localparam int W   = 32;
    localparam int TO  = 64;
    localparam int TOL = 1;

    logic         CCLK;
    logic         RST;
    logic         enable;
    logic         clk_in;
    logic [W-1:0] half_period;
    logic [W-1:0] scale_est;
    logic         valid;
    logic         locked;
    logic         timeout;

    int checks;
    int failures;
    int cyc;
    bit saw_to;

    int vh_q[$];
    int vs_q[$];
    bit vl_q[$];
    int vc_q[$];
    int eh_q[$];
    bit el_q[$];

    clk_period_meter #(
        .WIDTH(W),
        .TIMEOUT_CYCLES(TO),
        .TOL(TOL)
    ) dut (
        .CCLK(CCLK),
        .RST(RST),
        .enable(enable),
        .clk_in(clk_in),
        .half_period(half_period),
        .scale_est(scale_est),
        .valid(valid),
        .locked(locked),
        .timeout(timeout)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    always @(posedge CCLK) cyc <= cyc + 1;

    always @(negedge CCLK) begin
        if (valid) begin
            vh_q.push_back(int'(half_period));
            vs_q.push_back(int'(scale_est));
            vl_q.push_back(locked);
            vc_q.push_back(cyc);
        end
        if (timeout) saw_to <= 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    task automatic clear_obs();
        vh_q.delete();
        vs_q.delete();
        vl_q.delete();
        vc_q.delete();
        saw_to = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        clk_in = 1'b0;
        RST    = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(1);
        clear_obs();
    endtask

    task automatic drive(input int lead, input int sp[$]);
        tick(lead);
        clk_in = ~clk_in;
        foreach (sp[i]) begin
            tick(sp[i]);
            clk_in = ~clk_in;
        end
        tick(8);
    endtask

    // Each spacing is the distance between two edges; a gap beyond the
    // timeout stalls, so the edge ending it starts a fresh measurement.
    task automatic model(input int sp[$]);
        bit have;
        int prev;
        int d;
        have = 1'b0;
        prev = 0;
        eh_q.delete();
        el_q.delete();
        foreach (sp[i]) begin
            if (sp[i] > TO) begin
                have = 1'b0;
            end else begin
                d = (sp[i] > prev) ? sp[i] - prev : prev - sp[i];
                eh_q.push_back(sp[i]);
                el_q.push_back(have && (d <= TOL));
                have = 1'b1;
                prev = sp[i];
            end
        end
    endtask

    task automatic test_reset();
        enable = 1'b0;
        clk_in = 1'b0;
        RST    = 1'b1;
        tick(2);
        checks++;
        if (half_period !== '0 || scale_est !== '0) begin
            failures++;
            $display("FAIL reset_data hp=%0d se=%0d want 0 0",
                     half_period, scale_est);
        end
        checks++;
        if ({valid, locked, timeout} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags v/l/t=%b want 000",
                     {valid, locked, timeout});
        end
        RST = 1'b0;
        tick(1);
    endtask

    task automatic test_pattern(input string name, input int lead,
                                input int sp[$], input bit timing);
        int n;
        int es;
        do_reset();
        enable = 1'b1;
        drive(lead, sp);
        model(sp);
        checks++;
        if (vh_q.size() != eh_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d",
                     name, vh_q.size(), eh_q.size());
        end
        n = (vh_q.size() < eh_q.size()) ? vh_q.size() : eh_q.size();
        for (int i = 0; i < n; i++) begin
            es = (eh_q[i] > 0) ? eh_q[i] - 1 : 0;
            checks++;
            if (vh_q[i] != eh_q[i] || vs_q[i] != es || vl_q[i] != el_q[i]) begin
                failures++;
                $display("FAIL %s_cap%0d hp/se/lk got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         name, i, vh_q[i], vs_q[i], vl_q[i],
                         eh_q[i], es, el_q[i]);
            end
            if (timing && i > 0) begin
                checks++;
                if (vc_q[i] - vc_q[i-1] != eh_q[i]) begin
                    failures++;
                    $display("FAIL %s_gap%0d got=%0d want=%0d",
                             name, i, vc_q[i] - vc_q[i-1], eh_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int sp[$];
        int vc;
        int n;
        int guard;
        sp = '{5, 5, 5, 5};
        do_reset();
        enable = 1'b1;
        drive(2, sp);
        checks++;
        if (vl_q.size() != 4 || !vl_q[vl_q.size()-1]) begin
            failures++;
            $display("FAIL to_prelock n=%0d want 4 locked", vl_q.size());
        end
        vc = (vc_q.size() > 0) ? vc_q[vc_q.size()-1] : cyc;
        guard = 0;
        while (cyc < vc + 63 && guard < 300) begin
            @(negedge CCLK);
            guard++;
        end
        checks++;
        if (timeout !== 1'b0 || locked !== 1'b1 || guard >= 300) begin
            failures++;
            $display("FAIL to_early t/l=%b%b want 01 guard=%0d",
                     timeout, locked, guard);
        end
        @(negedge CCLK);
        checks++;
        if (timeout !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL to_assert t/l=%b%b want 10", timeout, locked);
        end
        tick(5);
        n = vh_q.size();
        clk_in = ~clk_in;
        tick(6);
        checks++;
        if (timeout !== 1'b0 || vh_q.size() != n) begin
            failures++;
            $display("FAIL to_clear t=%b new_valids=%0d want 0 0",
                     timeout, vh_q.size() - n);
        end
        clk_in = ~clk_in;
        tick(6);
        checks++;
        if (vh_q.size() != n + 1) begin
            failures++;
            $display("FAIL to_recap valids=%0d want 1", vh_q.size() - n);
        end else if (vh_q[n] != 6 || vl_q[n] != 1'b0) begin
            failures++;
            $display("FAIL to_recap hp/lk got=%0d/%0d want 6/0",
                     vh_q[n], vl_q[n]);
        end
    endtask

    task automatic test_coincide();
        int sp[$];
        sp = '{64, 64, 65, 64};
        test_pattern("coincide", 2, sp, 1'b0);
        checks++;
        if (vh_q.size() != 3 || vh_q[0] != TO || vh_q[1] != TO) begin
            failures++;
            $display("FAIL coincide_tmax n=%0d want 3 captures of %0d",
                     vh_q.size(), TO);
        end
        sp = '{5, 64, 64};
        test_pattern("coin_noto", 2, sp, 1'b0);
        checks++;
        if (saw_to !== 1'b0) begin
            failures++;
            $display("FAIL coin_noto timeout=%b want 0", saw_to);
        end
    endtask

    task automatic test_enable_drop();
        int sp[$];
        int n;
        sp = '{5, 5, 5};
        do_reset();
        enable = 1'b1;
        drive(2, sp);
        tick(2);
        enable = 1'b0;
        tick(2);
        checks++;
        if (locked !== 1'b0 || timeout !== 1'b0 ||
            half_period !== 32'd5 || scale_est !== 32'd4) begin
            failures++;
            $display("FAIL en_hold l/t=%b%b hp=%0d se=%0d want 00 5 4",
                     locked, timeout, half_period, scale_est);
        end
        n = vh_q.size();
        clk_in = ~clk_in;
        tick(6);
        clk_in = ~clk_in;
        tick(6);
        checks++;
        if (vh_q.size() != n || half_period !== 32'd5) begin
            failures++;
            $display("FAIL en_idle valids=%0d hp=%0d want 0 5",
                     vh_q.size() - n, half_period);
        end
        enable = 1'b1;
        tick(2);
        clk_in = ~clk_in;
        tick(5);
        clk_in = ~clk_in;
        tick(2);
        enable = 1'b0;
        tick(4);
        checks++;
        if (vh_q.size() != n) begin
            failures++;
            $display("FAIL en_edge valids=%0d want 0", vh_q.size() - n);
        end
    endtask

    task automatic test_rst_mid();
        int sp[$];
        sp = '{5, 5, 5};
        do_reset();
        enable = 1'b1;
        drive(2, sp);
        tick(1);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (half_period !== '0 || scale_est !== '0 ||
            {valid, locked, timeout} !== 3'b000) begin
            failures++;
            $display("FAIL rst_async hp=%0d se=%0d v/l/t=%b want 0 0 000",
                     half_period, scale_est, {valid, locked, timeout});
        end
        tick(1);
        RST = 1'b0;
        enable = 1'b0;
        tick(1);
    endtask

    task automatic test_random();
        int sp[$];
        int base;
        for (int r = 0; r < 4; r++) begin
            sp.delete();
            base = $urandom_range(20, 2);
            for (int k = 0; k < 14; k++) begin
                if ($urandom_range(7, 0) == 0) begin
                    sp.push_back($urandom_range(70, 60));
                end else begin
                    sp.push_back(base + $urandom_range(2, 0));
                end
            end
            test_pattern("random", 2, sp, 1'b0);
        end
    endtask

    initial begin
        int sp[$];
        checks   = 0;
        failures = 0;
        cyc      = 0;
        saw_to   = 1'b0;
        RST      = 1'b1;
        enable   = 1'b0;
        clk_in   = 1'b0;
        test_reset();
        sp = '{5, 5, 5, 5, 5, 5};
        test_pattern("basic", 2, sp, 1'b1);
        sp = '{1, 1, 1, 1, 1, 1};
        test_pattern("fast", 2, sp, 1'b1);
        sp = '{5, 5, 5, 9, 9, 9};
        test_pattern("change", 2, sp, 1'b1);
        sp = '{6, 7, 6, 7, 6, 7, 6};
        test_pattern("jit67", 3, sp, 1'b1);
        sp = '{6, 8, 6, 8, 6, 8, 6};
        test_pattern("jit68", 3, sp, 1'b1);
        test_timeout();
        test_coincide();
        test_enable_drop();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
